// File: rtl/mips_mc_pkg.sv
// Shared definitions for the multi-cycle MIPS controller: state encoding,
// instruction field constants, datapath select codes and the control bundle.
package mips_mc_pkg;

    localparam int unsigned OP_W  = 6;
    localparam int unsigned FN_W  = 6;
    localparam int unsigned ALU_W = 3;
    localparam int unsigned SEL_W = 2;
    localparam int unsigned ST_W  = 4;

    typedef enum logic [ST_W-1:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADR  = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_R_EXE    = 4'd6,
        S_R_WB     = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDI_EXE = 4'd9,
        S_ADDI_WB  = 4'd10,
        S_JUMP     = 4'd11,
        S_JAL      = 4'd12,
        S_JR       = 4'd13
    } state_e;

    // Opcodes (inst[31:26])
    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;
    localparam logic [OP_W-1:0] OP_JAL   = 6'b000011;

    // R-type function codes (inst[5:0])
    localparam logic [FN_W-1:0] FN_ADD = 6'b100000;
    localparam logic [FN_W-1:0] FN_SUB = 6'b100010;
    localparam logic [FN_W-1:0] FN_AND = 6'b100100;
    localparam logic [FN_W-1:0] FN_OR  = 6'b100101;
    localparam logic [FN_W-1:0] FN_SLT = 6'b101010;
    localparam logic [FN_W-1:0] FN_JR  = 6'b001000;

    localparam logic [ALU_W-1:0] ALU_ADD = 3'b010;
    localparam logic [ALU_W-1:0] ALU_SUB = 3'b110;
    localparam logic [ALU_W-1:0] ALU_AND = 3'b000;
    localparam logic [ALU_W-1:0] ALU_OR  = 3'b001;
    localparam logic [ALU_W-1:0] ALU_SLT = 3'b111;

    localparam logic [SEL_W-1:0] PC_SRC_ALU    = 2'b00;
    localparam logic [SEL_W-1:0] PC_SRC_ALUOUT = 2'b01;
    localparam logic [SEL_W-1:0] PC_SRC_JUMP   = 2'b10;
    localparam logic [SEL_W-1:0] PC_SRC_REGA   = 2'b11;

    localparam logic [SEL_W-1:0] REG_DST_RT  = 2'b00;
    localparam logic [SEL_W-1:0] REG_DST_RD  = 2'b01;
    localparam logic [SEL_W-1:0] REG_DST_R31 = 2'b10;

    localparam logic [SEL_W-1:0] M2R_ALUOUT = 2'b00;
    localparam logic [SEL_W-1:0] M2R_MDR    = 2'b01;
    localparam logic [SEL_W-1:0] M2R_PC     = 2'b10;

    localparam logic [SEL_W-1:0] SRCB_REGB  = 2'b00;
    localparam logic [SEL_W-1:0] SRCB_FOUR  = 2'b01;
    localparam logic [SEL_W-1:0] SRCB_IMM   = 2'b10;
    localparam logic [SEL_W-1:0] SRCB_IMMSH = 2'b11;

    localparam logic SRCA_PC      = 1'b0;
    localparam logic SRCA_REGA    = 1'b1;
    localparam logic ADDR_PC      = 1'b0;
    localparam logic ADDR_ALUOUT  = 1'b1;

    // Per-state control bundle before reset gating
    typedef struct packed {
        logic             mem_read;
        logic             mem_write;
        logic             i_or_d;
        logic             ir_write;
        logic             pc_write;
        logic             pc_write_cond;
        logic [SEL_W-1:0] pc_src;
        logic [SEL_W-1:0] reg_dst;
        logic [SEL_W-1:0] mem_to_reg;
        logic             reg_write;
        logic             alu_src_a;
        logic [SEL_W-1:0] alu_src_b;
        logic [ALU_W-1:0] alu_ctrl;
        logic             instr_done;
    } ctrl_t;

endpackage

// File: rtl/mips_alu_decoder.sv
// R-type function field to ALU operation decode; unknown functs default to add.
module mips_alu_decoder
    import mips_mc_pkg::*;
(
    input  logic [FN_W-1:0]  funct,
    output logic [ALU_W-1:0] alu_ctrl_c
);

    always_comb begin : p_decode
        alu_ctrl_c = ALU_ADD;
        case (funct)
            FN_ADD:  alu_ctrl_c = ALU_ADD;
            FN_SUB:  alu_ctrl_c = ALU_SUB;
            FN_AND:  alu_ctrl_c = ALU_AND;
            FN_OR:   alu_ctrl_c = ALU_OR;
            FN_SLT:  alu_ctrl_c = ALU_SLT;
            default: alu_ctrl_c = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mips_mc_controller.sv
// Multi-cycle MIPS control unit: Moore FSM sequencing fetch, decode and the
// per-class execute/writeback states; all strobes forced low while rst is low.
module mips_mc_controller
    import mips_mc_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [OP_W-1:0]  opcode,
    input  logic [FN_W-1:0]  funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_read,
    output logic             mem_write,
    output logic             i_or_d,
    output logic             ir_write,
    output logic             pc_en,
    output logic [SEL_W-1:0] pc_src,
    output logic [SEL_W-1:0] reg_dst,
    output logic [SEL_W-1:0] mem_to_reg,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [SEL_W-1:0] alu_src_b,
    output logic [ALU_W-1:0] alu_ctrl,
    output logic             instr_done
);

    state_e           state_q;
    state_e           state_d;
    ctrl_t            ctrl_c;
    ctrl_t            ctrl_g;
    logic [ALU_W-1:0] r_alu_c;

    mips_alu_decoder u_alu_dec (
        .funct      (funct),
        .alu_ctrl_c (r_alu_c)
    );

    always_ff @(posedge clk or negedge rst) begin : p_state
        if (!rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin : p_next
        state_d = state_q;
        unique case (state_q)
            S_FETCH:    if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW,
                    OP_SW:    state_d = S_MEM_ADR;
                    OP_RTYPE: state_d = (funct == FN_JR) ? S_JR : S_R_EXE;
                    OP_BEQ:   state_d = S_BRANCH;
                    OP_ADDI:  state_d = S_ADDI_EXE;
                    OP_J:     state_d = S_JUMP;
                    OP_JAL:   state_d = S_JAL;
                    default:  state_d = S_FETCH;
                endcase
            end
            S_MEM_ADR:  state_d = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   if (mem_ready) state_d = S_MEM_WB;
            S_MEM_WR:   if (mem_ready) state_d = S_FETCH;
            S_R_EXE:    state_d = S_R_WB;
            S_ADDI_EXE: state_d = S_ADDI_WB;
            default:    state_d = S_FETCH;
        endcase
    end

    // Everything not set in a state stays at the all-zero default.
    always_comb begin : p_out
        ctrl_c = '0;
        unique case (state_q)
            S_FETCH: begin
                ctrl_c.mem_read  = 1'b1;
                ctrl_c.i_or_d    = ADDR_PC;
                ctrl_c.alu_src_a = SRCA_PC;
                ctrl_c.alu_src_b = SRCB_FOUR;
                ctrl_c.alu_ctrl  = ALU_ADD;
                ctrl_c.pc_src    = PC_SRC_ALU;
                ctrl_c.ir_write  = mem_ready;
                ctrl_c.pc_write  = mem_ready;
            end
            S_DECODE: begin
                ctrl_c.alu_src_a = SRCA_PC;
                ctrl_c.alu_src_b = SRCB_IMMSH;
                ctrl_c.alu_ctrl  = ALU_ADD;
            end
            S_MEM_ADR, S_ADDI_EXE: begin
                ctrl_c.alu_src_a = SRCA_REGA;
                ctrl_c.alu_src_b = SRCB_IMM;
                ctrl_c.alu_ctrl  = ALU_ADD;
            end
            S_MEM_RD: begin
                ctrl_c.mem_read = 1'b1;
                ctrl_c.i_or_d   = ADDR_ALUOUT;
            end
            S_MEM_WB: begin
                ctrl_c.reg_dst    = REG_DST_RT;
                ctrl_c.mem_to_reg = M2R_MDR;
                ctrl_c.reg_write  = 1'b1;
                ctrl_c.instr_done = 1'b1;
            end
            S_MEM_WR: begin
                ctrl_c.mem_write  = 1'b1;
                ctrl_c.i_or_d     = ADDR_ALUOUT;
                ctrl_c.instr_done = mem_ready;
            end
            S_R_EXE: begin
                ctrl_c.alu_src_a = SRCA_REGA;
                ctrl_c.alu_src_b = SRCB_REGB;
                ctrl_c.alu_ctrl  = r_alu_c;
            end
            S_R_WB: begin
                ctrl_c.reg_dst    = REG_DST_RD;
                ctrl_c.mem_to_reg = M2R_ALUOUT;
                ctrl_c.reg_write  = 1'b1;
                ctrl_c.instr_done = 1'b1;
            end
            S_BRANCH: begin
                ctrl_c.alu_src_a     = SRCA_REGA;
                ctrl_c.alu_src_b     = SRCB_REGB;
                ctrl_c.alu_ctrl      = ALU_SUB;
                ctrl_c.pc_src        = PC_SRC_ALUOUT;
                ctrl_c.pc_write_cond = 1'b1;
                ctrl_c.instr_done    = 1'b1;
            end
            S_ADDI_WB: begin
                ctrl_c.reg_dst    = REG_DST_RT;
                ctrl_c.mem_to_reg = M2R_ALUOUT;
                ctrl_c.reg_write  = 1'b1;
                ctrl_c.instr_done = 1'b1;
            end
            S_JUMP: begin
                ctrl_c.pc_src     = PC_SRC_JUMP;
                ctrl_c.pc_write   = 1'b1;
                ctrl_c.instr_done = 1'b1;
            end
            S_JAL: begin
                ctrl_c.pc_src     = PC_SRC_JUMP;
                ctrl_c.pc_write   = 1'b1;
                ctrl_c.reg_write  = 1'b1;
                ctrl_c.reg_dst    = REG_DST_R31;
                ctrl_c.mem_to_reg = M2R_PC;
                ctrl_c.instr_done = 1'b1;
            end
            S_JR: begin
                ctrl_c.pc_src     = PC_SRC_REGA;
                ctrl_c.pc_write   = 1'b1;
                ctrl_c.instr_done = 1'b1;
            end
            default: ;
        endcase
    end

    // Reset blanks the strobes combinationally, without waiting for a clock.
    assign ctrl_g = rst ? ctrl_c : '0;

    assign mem_read   = ctrl_g.mem_read;
    assign mem_write  = ctrl_g.mem_write;
    assign i_or_d     = ctrl_g.i_or_d;
    assign ir_write   = ctrl_g.ir_write;
    assign pc_en      = ctrl_g.pc_write | (ctrl_g.pc_write_cond & zero);
    assign pc_src     = ctrl_g.pc_src;
    assign reg_dst    = ctrl_g.reg_dst;
    assign mem_to_reg = ctrl_g.mem_to_reg;
    assign reg_write  = ctrl_g.reg_write;
    assign alu_src_a  = ctrl_g.alu_src_a;
    assign alu_src_b  = ctrl_g.alu_src_b;
    assign alu_ctrl   = ctrl_g.alu_ctrl;
    assign instr_done = ctrl_g.instr_done;

endmodule

// File: tb/tb_mips_mc_controller.sv
// Directed-vector bench for mips_mc_controller: per-cycle expected control
// words for each instruction class, plus reset-in-flight sequences.
module tb_mips_mc_controller;

    typedef struct packed {
        logic       rd;
        logic       wr;
        logic       iod;
        logic       irw;
        logic       pcen;
        logic [1:0] pcsrc;
        logic [1:0] rdst;
        logic [1:0] m2r;
        logic       rw;
        logic       sa;
        logic [1:0] sb;
        logic [2:0] alu;
        logic       done;
    } out_t;

    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        logic       z;
        logic       rdy;
        out_t       exp;
    } vec_t;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000,
                           BEQ = 6'b000100, ADDI = 6'b001000, J = 6'b000010,
                           JAL = 6'b000011, BAD = 6'b111111;

    logic       clk;
    logic       rst;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       mem_read, mem_write, i_or_d, ir_write, pc_en;
    logic [1:0] pc_src, reg_dst, mem_to_reg;
    logic       reg_write, alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_ctrl;
    logic       instr_done;

    out_t act;
    vec_t tbl[$];
    int   total;
    int   bad;

    out_t o_fetch, o_fstall, o_dec, o_madr, o_mrd, o_mwb, o_mwr, o_mwr_st;
    out_t o_rwb, o_awb, o_beq_t, o_beq_f, o_j, o_jal, o_jr, o_zero;

    mips_mc_controller dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .funct      (funct),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .i_or_d     (i_or_d),
        .ir_write   (ir_write),
        .pc_en      (pc_en),
        .pc_src     (pc_src),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .reg_write  (reg_write),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_ctrl   (alu_ctrl),
        .instr_done (instr_done)
    );

    assign act = {mem_read, mem_write, i_or_d, ir_write, pc_en, pc_src, reg_dst,
                  mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_ctrl, instr_done};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1);
    end

    function automatic out_t mk(input logic rd, wr, iod, irw, pcen,
                                input logic [1:0] pcsrc, rdst, m2r,
                                input logic rw, sa, input logic [1:0] sb,
                                input logic [2:0] alu, input logic done);
        out_t o;
        o.rd = rd; o.wr = wr; o.iod = iod; o.irw = irw; o.pcen = pcen;
        o.pcsrc = pcsrc; o.rdst = rdst; o.m2r = m2r; o.rw = rw; o.sa = sa;
        o.sb = sb; o.alu = alu; o.done = done;
        return o;
    endfunction

    function automatic out_t rexe(input logic [2:0] alu);
        return mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 1, 2'b00, alu, 0);
    endfunction

    task automatic add(input logic [5:0] op, fn, input logic z, rdy, input out_t e);
        vec_t v;
        v.op = op; v.fn = fn; v.z = z; v.rdy = rdy; v.exp = e;
        tbl.push_back(v);
    endtask

    task automatic fd(input logic [5:0] op, fn, input logic z);
        add(op, fn, z, 1'b1, o_fetch);
        add(op, fn, z, 1'b1, o_dec);
    endtask

    task automatic check(input string name, input out_t e);
        total++;
        if (act !== e) begin
            bad++;
            $display("FAIL %s: got=%05h want=%05h", name, act, e);
        end
    endtask

    task automatic step(input logic [5:0] op, fn, input logic z, rdy);
        @(negedge clk);
        opcode = op; funct = fn; zero = z; mem_ready = rdy;
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        o_fetch  = mk(1, 0, 0, 1, 1, 2'b00, 2'b00, 2'b00, 0, 0, 2'b01, 3'b010, 0);
        o_fstall = mk(1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 2'b01, 3'b010, 0);
        o_dec    = mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 2'b11, 3'b010, 0);
        o_madr   = mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0, 1, 2'b10, 3'b010, 0);
        o_mrd    = mk(1, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00, 3'b000, 0);
        o_mwb    = mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b01, 1, 0, 2'b00, 3'b000, 1);
        o_mwr    = mk(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00, 3'b000, 1);
        o_mwr_st = mk(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 0, 0, 2'b00, 3'b000, 0);
        o_rwb    = mk(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b00, 1, 0, 2'b00, 3'b000, 1);
        o_awb    = mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1, 0, 2'b00, 3'b000, 1);
        o_beq_t  = mk(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 0, 1, 2'b00, 3'b110, 1);
        o_beq_f  = mk(0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0, 1, 2'b00, 3'b110, 1);
        o_j      = mk(0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00, 0, 0, 2'b00, 3'b000, 1);
        o_jal    = mk(0, 0, 0, 0, 1, 2'b10, 2'b10, 2'b10, 1, 0, 2'b00, 3'b000, 1);
        o_jr     = mk(0, 0, 0, 0, 1, 2'b11, 2'b00, 2'b00, 0, 0, 2'b00, 3'b000, 1);
        o_zero   = '0;

        // lw, sw, each with and without memory wait states
        fd(LW, 6'd0, 0); add(LW, 6'd0, 0, 1, o_madr); add(LW, 6'd0, 0, 1, o_mrd);
        add(LW, 6'd0, 0, 1, o_mwb);
        fd(SW, 6'd0, 0); add(SW, 6'd0, 0, 1, o_madr); add(SW, 6'd0, 0, 1, o_mwr);
        fd(SW, 6'd0, 0); add(SW, 6'd0, 0, 1, o_madr); add(SW, 6'd0, 0, 0, o_mwr_st);
        add(SW, 6'd0, 0, 0, o_mwr_st); add(SW, 6'd0, 0, 1, o_mwr);
        fd(LW, 6'd0, 0); add(LW, 6'd0, 0, 1, o_madr); add(LW, 6'd0, 0, 0, o_mrd);
        add(LW, 6'd0, 0, 1, o_mrd); add(LW, 6'd0, 0, 1, o_mwb);
        // fetch stalled three cycles, then addi
        add(ADDI, 6'd0, 0, 0, o_fstall); add(ADDI, 6'd0, 0, 0, o_fstall);
        add(ADDI, 6'd0, 0, 0, o_fstall); add(ADDI, 6'd0, 0, 1, o_fetch);
        add(ADDI, 6'd0, 0, 1, o_dec); add(ADDI, 6'd0, 0, 1, o_madr);
        add(ADDI, 6'd0, 0, 1, o_awb);
        // R-type ALU decode, including an unlisted funct
        fd(RT, 6'b100000, 0); add(RT, 6'b100000, 0, 1, rexe(3'b010)); add(RT, 6'b100000, 0, 1, o_rwb);
        fd(RT, 6'b100010, 0); add(RT, 6'b100010, 0, 1, rexe(3'b110)); add(RT, 6'b100010, 0, 1, o_rwb);
        fd(RT, 6'b100100, 1); add(RT, 6'b100100, 1, 1, rexe(3'b000)); add(RT, 6'b100100, 1, 1, o_rwb);
        fd(RT, 6'b100101, 0); add(RT, 6'b100101, 0, 1, rexe(3'b001)); add(RT, 6'b100101, 0, 1, o_rwb);
        fd(RT, 6'b101010, 0); add(RT, 6'b101010, 0, 1, rexe(3'b111)); add(RT, 6'b101010, 0, 1, o_rwb);
        fd(RT, 6'b000111, 0); add(RT, 6'b000111, 0, 1, rexe(3'b010)); add(RT, 6'b000111, 0, 1, o_rwb);
        // branches and jumps
        fd(BEQ, 6'd0, 1); add(BEQ, 6'd0, 1, 1, o_beq_t);
        fd(BEQ, 6'd0, 0); add(BEQ, 6'd0, 0, 1, o_beq_f);
        fd(J, 6'd0, 0);   add(J, 6'd0, 0, 1, o_j);
        fd(JAL, 6'd0, 0); add(JAL, 6'd0, 0, 1, o_jal);
        fd(RT, 6'b001000, 1); add(RT, 6'b001000, 1, 1, o_jr);
        // unknown opcode: decode then straight back to fetch
        fd(BAD, 6'd0, 0);

        // Reset is asserted asynchronously and holds outputs low across edges
        rst = 1'b1; opcode = LW; funct = '0; zero = 1'b0; mem_ready = 1'b1;
        #1 rst = 1'b0;
        #2 check("reset_async", o_zero);
        @(negedge clk); #1 check("reset_held", o_zero);
        @(negedge clk);
        rst = 1'b1;

        foreach (tbl[i]) begin
            opcode = tbl[i].op; funct = tbl[i].fn;
            zero = tbl[i].z; mem_ready = tbl[i].rdy;
            #1;
            check($sformatf("vec%0d", i), tbl[i].exp);
            @(negedge clk);
        end

        // After the bad opcode the next cycle must be fetch again
        opcode = SW; funct = '0; zero = 1'b0; mem_ready = 1'b1;
        #1 check("bad_op_refetch", o_fetch);
        step(SW, 6'd0, 0, 1); check("rst_seq_dec", o_dec);
        step(SW, 6'd0, 0, 1); check("rst_seq_madr", o_madr);
        step(SW, 6'd0, 0, 0); check("rst_seq_mwr", o_mwr_st);
        #2 rst = 1'b0;
        #1 check("rst_mwr_drop", o_zero);
        step(SW, 6'd0, 0, 1); check("rst_mwr_held", o_zero);
        rst = 1'b1;
        #1 check("rst_release_fetch", o_fetch);
        step(SW, 6'd0, 0, 1); check("post_rst_dec", o_dec);
        step(SW, 6'd0, 0, 1); check("post_rst_madr", o_madr);
        step(SW, 6'd0, 0, 1); check("post_rst_mwr", o_mwr);
        step(J, 6'd0, 0, 1);  check("post_rst_fetch", o_fetch);

        // Reset while fetch is stalled: strobes drop, fetch resumes after release
        step(J, 6'd0, 0, 1);  check("j_dec", o_dec);
        step(J, 6'd0, 0, 1);  check("j_jump", o_j);
        step(LW, 6'd0, 0, 0); check("stall_fetch", o_fstall);
        rst = 1'b0;
        #1 check("rst_in_fetch", o_zero);
        step(LW, 6'd0, 0, 1); check("rst_in_fetch_held", o_zero);
        rst = 1'b1;
        #1 check("fetch_after_rst", o_fetch);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mips_mc_controller.md
MIPS_MC_CONTROLLER -- requirements
Module: mips_mc_controller

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1, reset; asynchronous, active-low.
REQ-003 SHALL have port opcode, input, 6, inst[31:26] from the instruction register.
REQ-004 SHALL have port funct, input, 6, inst[5:0] from the instruction register.
REQ-005 SHALL have port zero, input, 1, ALU zero flag.
REQ-006 SHALL have port mem_ready, input, 1, shared-memory access complete this cycle.
REQ-007 SHALL have port mem_read / mem_write, output, 1 each, shared-memory strobes.
REQ-008 SHALL have port i_or_d, output, 1: 0 = PC address, 1 = ALUOut address.
REQ-009 SHALL have port ir_write, output, 1, instruction register load.
REQ-010 SHALL have port pc_en, output, 1: pc_write | (pc_write_cond & zero).
REQ-011 SHALL have port pc_src, output, 2: 00 ALU, 01 ALUOut, 10 jump target, 11 register A.
REQ-012 SHALL have port reg_dst, output, 2: 00 rt, 01 rd, 10 r31.
REQ-013 SHALL have port mem_to_reg, output, 2: 00 ALUOut, 01 MDR, 10 PC.
REQ-014 SHALL have port reg_write, output, 1; alu_src_a, output, 1 (0 PC, 1 A); alu_src_b, output, 2 (00 B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2).
REQ-015 SHALL have port alu_ctrl, output, 3: 010 add, 110 sub, 000 and, 001 or, 111 slt.
REQ-016 SHALL have port instr_done, output, 1, one-cycle pulse on the final state of each instruction.

Function
REQ-017 SHALL be a Moore FSM with states FETCH, DECODE, MEM_ADR, MEM_RD, MEM_WB, MEM_WR, R_EXE, R_WB, BRANCH, ADDI_EXE, ADDI_WB, JUMP, JAL, JR.
REQ-018 In FETCH: mem_read=1, i_or_d=0, src_a=0, src_b=01, add, pc_src=00; ir_write and pc_write asserted only when mem_ready=1; remain in FETCH until mem_ready=1, then go to DECODE.
REQ-019 In DECODE: src_a=0, src_b=11, add; next state by opcode: 100011/101011 -> MEM_ADR; 000000 with funct 001000 -> JR; other 000000 -> R_EXE; 000100 -> BRANCH; 001000 -> ADDI_EXE; 000010 -> JUMP; 000011 -> JAL; any other -> FETCH with no writes and no instr_done.
REQ-020 In MEM_ADR: src_a=1, src_b=10, add; next is MEM_RD for lw, MEM_WR for sw.
REQ-021 In MEM_RD: mem_read=1, i_or_d=1; hold until mem_ready=1, then MEM_WB. In MEM_WB: reg_dst=00, mem_to_reg=01, reg_write=1, then FETCH.
REQ-022 In MEM_WR: mem_write=1, i_or_d=1; hold until mem_ready=1, then FETCH.
REQ-023 In R_EXE: src_a=1, src_b=00, alu_ctrl from funct (100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt, other add). In R_WB: reg_dst=01, mem_to_reg=00, reg_write=1.
REQ-024 In BRANCH: src_a=1, src_b=00, sub, pc_src=01, pc_write_cond=1.
REQ-025 ADDI_EXE: src_a=1, src_b=10, add. ADDI_WB: reg_dst=00, mem_to_reg=00, reg_write=1.
REQ-026 JUMP: pc_src=10, pc_write=1. JAL: pc_src=10, pc_write=1, reg_write=1, reg_dst=10, mem_to_reg=10. JR: pc_src=11, pc_write=1.
REQ-027 MEM_WB, MEM_WR (on the cycle mem_ready=1), R_WB, BRANCH, ADDI_WB, JUMP, JAL, JR SHALL assert instr_done and return to FETCH.
REQ-028 Unlisted outputs SHALL be 0 in every state; mem_read and mem_write SHALL never be asserted together.
REQ-029 Latency with mem_ready tied high: lw 5, sw/R/addi 4, beq/j/jal/jr 3 cycles.

Reset
REQ-030 While rst=0 the state SHALL be FETCH and every output SHALL be forced to 0, independent of the clock.
REQ-031 Reset asserted mid-instruction SHALL abandon it; after release the first cycle SHALL be FETCH.

Structure
REQ-032 State encoding, opcode, funct and alu_ctrl constants SHALL reside in shared package mips_mc_pkg.
REQ-033 The funct-to-alu_ctrl decode SHALL be sub-module mips_alu_decoder.

Verification
REQ-034 lw (op 100011), mem_ready=1 -> FETCH, DECODE, MEM_ADR, MEM_RD, MEM_WB; reg_write=1 with mem_to_reg=01 in cycle 5.
REQ-035 FETCH with mem_ready low for 3 cycles -> mem_read held at 1, ir_write=0 and pc_en=0 for those cycles, both 1 in cycle 4.
REQ-036 beq with zero=1 -> pc_en=1 and pc_src=01 in BRANCH; repeated with zero=0 -> pc_en=0.
REQ-037 jal -> JAL cycle shows reg_dst=10, mem_to_reg=10, reg_write=1, pc_en=1, instr_done=1.
REQ-038 Opcode 111111 -> DECODE then FETCH, reg_write, mem_write and instr_done all 0.
REQ-039 rst=0 asserted during MEM_WR -> mem_write drops to 0 immediately; after release the state is FETCH.
